// File: rtl/hpi_responder.sv
// -----------------------------------------------------------------------------
// hpi_responder
//   Host-port-interface slave. It exposes four host registers:
//     DATA    - RAM window at addr_reg, auto-increments by 2 per access
//     MAILBOX - host write -> local rx word, host read <- local tx word
//     ADDRESS - 16-bit byte address register
//     STATUS  - {ERR, 13'b0, tx_full, rx_full}
//   It also holds a 2^AW x 16-bit RAM.
//
// Ports
//   clk_clk        single clock, rising edge
//   reset_reset_n  async active-low reset
//   hpi_rst_n      host soft reset, active-low, synchronous
//   hpi_cs_n/r_n/w_n, hpi_addr, hpi_data_in   host access inputs
//   hpi_data_out   registered read data, held until the next read
//   hpi_int        registered interrupt = tx_full | ERR
//   mbx_rx_data/valid/ack   host->local mailbox
//   mbx_tx_data/post        local->host mailbox
//
// Build option
//   HPI_RESP_ERR_EN - when defined, a chip-select with both strobes low sets
//                     a sticky ERR flag. Otherwise ERR is constant 0.
// -----------------------------------------------------------------------------
module hpi_responder #(
   parameter int AW = 8
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        hpi_rst_n,
   input  logic        hpi_cs_n,
   input  logic        hpi_r_n,
   input  logic        hpi_w_n,
   input  logic [1:0]  hpi_addr,
   input  logic [15:0] hpi_data_in,
   output logic [15:0] hpi_data_out,
   output logic        hpi_int,
   output logic [15:0] mbx_rx_data,
   output logic        mbx_rx_valid,
   input  logic        mbx_rx_ack,
   input  logic [15:0] mbx_tx_data,
   input  logic        mbx_tx_post
);

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_MBX  = 2'd1;
   localparam logic [1:0] A_ADDR = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   logic [15:0]   r_mem [0:(1<<AW)-1];
   logic [15:0]   r_addr;
   logic [15:0]   r_tx_data;
   logic          r_tx_full;
   logic          r_rx_full;
   logic          r_armed;     // previous cycle did not qualify as an access

   logic          w_rd_q, w_wr_q, w_qual, w_both_low;
   logic          w_rd_start, w_wr_start, w_mbx_rd;
   logic [AW-1:0] w_idx;
   logic          w_tx_full_nx;
   logic [15:0]   w_tx_data_nx;
   logic          w_err, w_err_nx;

   assign w_rd_q     = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
   assign w_wr_q     = !hpi_cs_n &&  hpi_r_n && !hpi_w_n;
   assign w_qual     = w_rd_q || w_wr_q;
   assign w_both_low = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
   // r_armed resets to 0, so a strobe already low at reset release is ignored
   // until it goes away.
   assign w_rd_start = w_rd_q && r_armed && hpi_rst_n;
   assign w_wr_start = w_wr_q && r_armed && hpi_rst_n;
   assign w_mbx_rd   = w_rd_start && (hpi_addr == A_MBX);
   assign w_idx      = r_addr[AW:1];

   // A host read of MAILBOX frees the slot in the same cycle, so a coincident
   // post is accepted and leaves the new word pending.
   always_comb begin
      w_tx_full_nx = r_tx_full;
      w_tx_data_nx = r_tx_data;
      if (w_mbx_rd)
         w_tx_full_nx = 1'b0;
      if (mbx_tx_post && (!r_tx_full || w_mbx_rd)) begin
         w_tx_full_nx = 1'b1;
         w_tx_data_nx = mbx_tx_data;
      end
   end

`ifdef HPI_RESP_ERR_EN
   logic r_err;
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)  r_err <= 1'b0;
      else if (!hpi_rst_n) r_err <= 1'b0;
      else                 r_err <= w_err_nx;
   end
   assign w_err    = r_err;
   assign w_err_nx = r_err || w_both_low;
`else
   assign w_err    = 1'b0;
   assign w_err_nx = 1'b0;
`endif

   // RAM contents are not reset.
   always_ff @(posedge clk_clk) begin
      if (w_wr_start && (hpi_addr == A_DATA))
         r_mem[w_idx] <= hpi_data_in;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_addr       <= '0;
         hpi_data_out <= '0;
         mbx_rx_data  <= '0;
         r_tx_data    <= '0;
         r_rx_full    <= 1'b0;
         r_tx_full    <= 1'b0;
         hpi_int      <= 1'b0;
         r_armed      <= 1'b0;
      end else if (!hpi_rst_n) begin
         r_addr       <= '0;
         hpi_data_out <= '0;
         mbx_rx_data  <= '0;
         r_tx_data    <= '0;
         r_rx_full    <= 1'b0;
         r_tx_full    <= 1'b0;
         hpi_int      <= 1'b0;
         r_armed      <= 1'b0;
      end else begin
         r_armed   <= !w_qual;
         r_tx_full <= w_tx_full_nx;
         r_tx_data <= w_tx_data_nx;
         hpi_int   <= w_tx_full_nx || w_err_nx;

         // A host write wins over a coincident local ack.
         if (w_wr_start && (hpi_addr == A_MBX))
            r_rx_full <= 1'b1;
         else if (mbx_rx_ack)
            r_rx_full <= 1'b0;

         if (w_wr_start) begin
            case (hpi_addr)
               A_DATA: r_addr      <= r_addr + 16'd2;
               A_MBX:  mbx_rx_data <= hpi_data_in;
               A_ADDR: r_addr      <= hpi_data_in;
               A_STAT: ;
            endcase
         end

         if (w_rd_start) begin
            case (hpi_addr)
               A_DATA: begin
                  hpi_data_out <= r_mem[w_idx];
                  r_addr       <= r_addr + 16'd2;
               end
               A_MBX:  hpi_data_out <= r_tx_data;
               A_ADDR: hpi_data_out <= r_addr;
               A_STAT: hpi_data_out <= {w_err, 13'b0, r_tx_full, r_rx_full};
            endcase
         end
      end
   end

   assign mbx_rx_valid = r_rx_full;

endmodule

// File: tb/tb_hpi_responder.sv
// -----------------------------------------------------------------------------
// tb_hpi_responder
//   Directed bench for hpi_responder: RAM window with auto-increment and
//   wrap, mailboxes in both directions including coincident events, host
//   soft reset in the middle of a strobe, and the both-strobes-low case.
// -----------------------------------------------------------------------------
module tb_hpi_responder;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_MBX  = 2'd1;
   localparam logic [1:0] A_ADDR = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hrst_n;
   logic        cs_n, r_n, w_n;
   logic [1:0]  addr;
   logic [15:0] din;
   logic [15:0] dout;
   logic        intr;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ack;
   logic [15:0] tx_data;
   logic        tx_post;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] rd;

   always #5 clk = ~clk;

   hpi_responder #(.AW(8)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .hpi_rst_n     (hrst_n),
      .hpi_cs_n      (cs_n),
      .hpi_r_n       (r_n),
      .hpi_w_n       (w_n),
      .hpi_addr      (addr),
      .hpi_data_in   (din),
      .hpi_data_out  (dout),
      .hpi_int       (intr),
      .mbx_rx_data   (rx_data),
      .mbx_rx_valid  (rx_valid),
      .mbx_rx_ack    (rx_ack),
      .mbx_tx_data   (tx_data),
      .mbx_tx_post   (tx_post)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic strobe_off();
      cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
   endtask

   // Strobe low for two edges, then high for one edge.
   task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      cs_n = 1'b0; w_n = 1'b0; addr = a; din = d;
      repeat (2) @(posedge clk);
      #1 strobe_off();
      @(posedge clk); #1;
   endtask

   task automatic host_rd(input logic [1:0] a, output logic [15:0] d);
      @(posedge clk); #1;
      cs_n = 1'b0; r_n = 1'b0; addr = a;
      repeat (2) @(posedge clk);
      #1 strobe_off();
      @(posedge clk); #1;
      d = dout;
   endtask

   task automatic post(input logic [15:0] d);
      @(posedge clk); #1;
      tx_post = 1'b1; tx_data = d;
      @(posedge clk); #1;
      tx_post = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; hrst_n = 1'b1; strobe_off();
      addr = 2'd0; din = '0; rx_ack = 1'b0; tx_data = '0; tx_post = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      chk("rst_dout", dout, 16'h0000);
      chk("rst_int", {15'b0, intr}, 16'h0000);
      chk("rst_rxv", {15'b0, rx_valid}, 16'h0000);
      host_rd(A_STAT, rd); chk("rst_status", rd, 16'h0000);
      host_rd(A_ADDR, rd); chk("rst_addr", rd, 16'h0000);

      // RAM window with auto-increment
      host_wr(A_ADDR, 16'h0010);
      host_wr(A_DATA, 16'h1111);
      host_wr(A_DATA, 16'h2222);
      host_wr(A_ADDR, 16'h0010);
      host_rd(A_DATA, rd); chk("ram_rd0", rd, 16'h1111);
      host_rd(A_DATA, rd); chk("ram_rd1", rd, 16'h2222);
      host_rd(A_ADDR, rd); chk("addr_inc", rd, 16'h0014);

      // address wrap and upper-bit aliasing (0xFFFE and 0x01FE share a word)
      host_wr(A_ADDR, 16'hFFFE);
      host_wr(A_DATA, 16'hABCD);
      host_rd(A_ADDR, rd); chk("addr_wrap", rd, 16'h0000);
      host_wr(A_ADDR, 16'h01FE);
      host_rd(A_DATA, rd); chk("ram_alias", rd, 16'hABCD);

      // local -> host mailbox
      post(16'h5A5A);
      chk("tx_int_set", {15'b0, intr}, 16'h0001);
      host_rd(A_STAT, rd); chk("tx_status_full", rd, 16'h0002);
      post(16'h1234);                     // dropped, slot occupied
      host_rd(A_MBX, rd); chk("tx_mbx_rd", rd, 16'h5A5A);
      chk("tx_int_clr", {15'b0, intr}, 16'h0000);
      host_rd(A_STAT, rd); chk("tx_status_empty", rd, 16'h0000);
      host_rd(A_MBX, rd); chk("tx_drop", rd, 16'h5A5A);

      // post coincident with host MAILBOX read start
      post(16'h1111);
      @(posedge clk); #1;
      cs_n = 1'b0; r_n = 1'b0; addr = A_MBX; tx_post = 1'b1; tx_data = 16'h7777;
      @(posedge clk); #1 tx_post = 1'b0;
      @(posedge clk); #1 strobe_off();
      @(posedge clk); #1;
      chk("tx_coinc_rd", dout, 16'h1111);
      chk("tx_coinc_int", {15'b0, intr}, 16'h0001);
      host_rd(A_MBX, rd); chk("tx_coinc_new", rd, 16'h7777);

      // host -> local mailbox
      host_wr(A_MBX, 16'h00C3);
      chk("rx_valid", {15'b0, rx_valid}, 16'h0001);
      chk("rx_data", rx_data, 16'h00C3);
      host_rd(A_STAT, rd); chk("rx_status", rd, 16'h0001);
      @(posedge clk); #1 rx_ack = 1'b1;
      @(posedge clk); #1 rx_ack = 1'b0;
      chk("rx_ack", {15'b0, rx_valid}, 16'h0000);

      // host write coincident with local ack: write wins
      host_wr(A_MBX, 16'h0011);
      @(posedge clk); #1;
      cs_n = 1'b0; w_n = 1'b0; addr = A_MBX; din = 16'h0055; rx_ack = 1'b1;
      @(posedge clk); #1 rx_ack = 1'b0;
      @(posedge clk); #1 strobe_off();
      @(posedge clk); #1;
      chk("rx_coinc_valid", {15'b0, rx_valid}, 16'h0001);
      chk("rx_coinc_data", rx_data, 16'h0055);

      // soft reset in the middle of a strobe, with tx_full set
      host_wr(A_ADDR, 16'h0040);
      post(16'hBEEF);
      @(posedge clk); #1;
      hrst_n = 1'b0; cs_n = 1'b0; w_n = 1'b0; addr = A_ADDR; din = 16'h0099;
      @(posedge clk); #1 hrst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 strobe_off();
      @(posedge clk); #1;
      chk("srst_int", {15'b0, intr}, 16'h0000);
      chk("srst_rxv", {15'b0, rx_valid}, 16'h0000);
      chk("srst_rxdata", rx_data, 16'h0000);
      host_rd(A_STAT, rd); chk("srst_status", rd, 16'h0000);
      host_rd(A_ADDR, rd); chk("srst_addr", rd, 16'h0000);
      host_wr(A_ADDR, 16'h0099);
      host_rd(A_ADDR, rd); chk("srst_reaccess", rd, 16'h0099);

      // both strobes low
      @(posedge clk); #1;
      cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0; addr = A_ADDR; din = 16'h0123;
      repeat (2) @(posedge clk);
      #1 strobe_off();
      @(posedge clk); #1;
`ifdef HPI_RESP_ERR_EN
      chk("err_int", {15'b0, intr}, 16'h0001);
      host_rd(A_STAT, rd); chk("err_status", rd, 16'h8000);
`else
      chk("err_int", {15'b0, intr}, 16'h0000);
      host_rd(A_STAT, rd); chk("err_status", rd, 16'h0000);
`endif
      host_rd(A_ADDR, rd); chk("err_no_access", rd, 16'h0099);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
